memwb_pipe: RTL and testbench
=============================

# memwb_pipe

Parametrised MEM/WB pipeline stage register with valid/ready handshake, synchronous flush, an optional 2-entry skid buffer, and a built-in write-back mux. It sits between the data-memory stage and the register-file write port. It replaces the fixed always-load latch with a stage that can stall, drop squashed instructions, and absorb one cycle of downstream back-pressure without losing data.

## Interface
- DATA_W, 32, width of read data, ALU result, and write-back data
- RADDR_W, 5, destination register index width
- SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single entry (combinational in_ready)
- CNT_W, 16, stall counter width
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  squash all held entries; synchronous
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_reg_write, in_mem_to_reg  in  1 each  WB control bits
- in_read_data, in_alu_result  in  DATA_W each  memory load data / ALU result
- in_rd  in  RADDR_W  destination register
- out_valid  out  1  head entry valid
- out_ready  in  1  write-back consumes head
- out_reg_write, out_mem_to_reg  out  1 each  head control bits
- out_read_data, out_alu_result  out  DATA_W  head data
- out_rd  out  RADDR_W  head destination
- wb_data  out  DATA_W  out_mem_to_reg ? out_read_data : out_alu_result
- wb_en  out  1  out_valid & out_ready & out_reg_write
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready; saturating

## Operation
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- Capture rule: if in_rd == 0, the stored reg_write is forced to 0; all other fields are stored unchanged.
- SKID=1 occupancy states:
  - EMPTY: accept -> ONE.
  - ONE: accept & !consume -> TWO, new entry goes to skid. Accept & consume -> ONE, main loads input. Consume only -> EMPTY.
  - TWO: in_ready = 0. Consume -> ONE, skid moves to main.
  - FIFO order is always preserved.
- SKID=0: single register. in_ready = !out_valid | out_ready. Accept loads main; consume without accept -> EMPTY.
- flush: next state EMPTY. It beats a same-cycle accept (the input is dropped) and a same-cycle consume (the consume still counts as taken by downstream). Data registers need not clear; valid bits must.
- stall_cnt increments each cycle with out_valid & !out_ready. It holds at 2^CNT_W-1 and is cleared only by reset.
- wb_data and wb_en are combinational from the head registers and out_ready.

## Timing
- Reset (rst_n low, asynchronous): state EMPTY, so out_valid = 0.
  - All out_* data and control = 0, wb_data = 0, wb_en = 0, stall_cnt = 0.
  - in_ready = 1 in both modes.
- Latency: an accept in cycle N makes out_valid high with the new fields in cycle N+1.
- SKID=1: in_ready is a register output, low exactly while in state TWO. No combinational path from out_ready to in_ready.
- Throughput: one instruction per cycle sustained while out_ready = 1.
- After flush in cycle N: out_valid = 0 and in_ready = 1 in cycle N+1.
- Reset deasserted mid-stream: the stage resumes from EMPTY; in-flight entries are lost.
- Head fields hold stable while out_valid & !out_ready.

## Test plan
- Reset, then in_valid with alu_result=0x0000_1234, rd=5, reg_write=1, mem_to_reg=0, out_ready=1 -> next cycle: out_valid=1, out_rd=5, wb_data=0x1234, wb_en=1.
- Back-pressure, SKID=1: send A, B, C back-to-back with out_ready=0 -> in_ready drops after B, C is held upstream. Raise out_ready -> output order A, B, C; stall_cnt equals the number of stalled cycles.
- Load select: in_mem_to_reg=1, read_data=0xDEAD_BEEF, alu_result=0x1 -> wb_data=0xDEAD_BEEF.
- rd = 0 with reg_write=1 -> out_reg_write=0 and wb_en=0 while out_valid=1.
- flush in state TWO together with in_valid -> next cycle: out_valid=0, in_ready=1, no entry ever appears at the output.
- Saturation: CNT_W=4, hold out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt=15. Assert rst_n low mid-stall -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/memwb_pipe_if.sv
// rtl/memwb_pipe_if.sv - MEM/WB stage handshake bundle: upstream capture side, head/write-back side, flush.
interface memwb_pipe_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic               in_reg_write;
  logic               in_mem_to_reg;
  logic [DATA_W-1:0]  in_read_data;
  logic [DATA_W-1:0]  in_alu_result;
  logic [RADDR_W-1:0] in_rd;
  logic               out_valid;
  logic               out_ready;
  logic               out_reg_write;
  logic               out_mem_to_reg;
  logic [DATA_W-1:0]  out_read_data;
  logic [DATA_W-1:0]  out_alu_result;
  logic [RADDR_W-1:0] out_rd;
  logic [DATA_W-1:0]  wb_data;
  logic               wb_en;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output flush, in_valid, in_reg_write, in_mem_to_reg, in_read_data, in_alu_result, in_rd,
    output out_ready,
    input  in_ready, out_valid, out_reg_write, out_mem_to_reg, out_read_data, out_alu_result,
    input  out_rd, wb_data, wb_en, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_reg_write, in_mem_to_reg, in_read_data, in_alu_result, in_rd,
    input  out_ready,
    output in_ready, out_valid, out_reg_write, out_mem_to_reg, out_read_data, out_alu_result,
    output out_rd, wb_data, wb_en, stall_cnt
  );
endinterface

// File: rtl/memwb_pipe.sv
// rtl/memwb_pipe.sv - MEM/WB stage register with valid/ready, flush, optional skid entry and write-back mux.
module memwb_pipe #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int SKID    = 1,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  memwb_pipe_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic [DATA_W-1:0]  read_data;
    logic [DATA_W-1:0]  alu_result;
    logic [RADDR_W-1:0] rd;
  } entry_t;

  state_t           state, state_n;
  entry_t           main_q, skid_q, in_entry;
  logic             out_valid, accept, consume;
  logic             load_main, load_skid, skid_to_main;
  logic [CNT_W-1:0] stall_q;

  // Writes to x0 are architecturally void, so they are neutered at capture.
  always_comb begin
    in_entry.reg_write  = bus.in_reg_write & (bus.in_rd != '0);
    in_entry.mem_to_reg = bus.in_mem_to_reg;
    in_entry.read_data  = bus.in_read_data;
    in_entry.alu_result = bus.in_alu_result;
    in_entry.rd         = bus.in_rd;
  end

  assign out_valid = (state != EMPTY);
  assign accept    = bus.in_valid & bus.in_ready;
  assign consume   = out_valid & bus.out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;
      // Registered ready: low exactly while both entries are occupied.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_ready_q <= 1'b1;
        else        in_ready_q <= (state_n != TWO);
      end
      assign bus.in_ready = in_ready_q;
    end else begin : g_single
      assign bus.in_ready = ~out_valid | bus.out_ready;
    end
  endgenerate

  always_comb begin
    state_n      = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (bus.flush) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_n   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          // Without a skid entry, accept in ONE already implies consume.
          if (accept && consume) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_n   = TWO;
            load_skid = 1'b1;
          end else if (consume) begin
            state_n = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            state_n      = ONE;
            skid_to_main = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            main_q <= '0;
    else if (load_main)    main_q <= in_entry;
    else if (skid_to_main) main_q <= skid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         skid_q <= '0;
    else if (load_skid) skid_q <= in_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (out_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign bus.out_valid      = out_valid;
  assign bus.out_reg_write  = main_q.reg_write;
  assign bus.out_mem_to_reg = main_q.mem_to_reg;
  assign bus.out_read_data  = main_q.read_data;
  assign bus.out_alu_result = main_q.alu_result;
  assign bus.out_rd         = main_q.rd;
  assign bus.wb_data        = main_q.mem_to_reg ? main_q.read_data : main_q.alu_result;
  assign bus.wb_en          = out_valid & bus.out_ready & main_q.reg_write;
  assign bus.stall_cnt      = stall_q;

endmodule

// File: tb/tb_memwb_pipe.sv
// tb/tb_memwb_pipe.sv - Randomized and directed bench for memwb_pipe against a queue model, skid and single-entry builds.
module tb_memwb_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush, in_valid, out_ready;
  logic        c_rw, c_m2r;
  logic [31:0] c_rdata, c_alu;
  logic [4:0]  c_rd;

  memwb_pipe_if #(.DATA_W(32), .RADDR_W(5), .CNT_W(4))  b1 ();
  memwb_pipe_if #(.DATA_W(32), .RADDR_W(5), .CNT_W(16)) b0 ();

  assign b1.flush = flush;         assign b0.flush = flush;
  assign b1.in_valid = in_valid;   assign b0.in_valid = in_valid;
  assign b1.out_ready = out_ready; assign b0.out_ready = out_ready;
  assign b1.in_reg_write = c_rw;   assign b0.in_reg_write = c_rw;
  assign b1.in_mem_to_reg = c_m2r; assign b0.in_mem_to_reg = c_m2r;
  assign b1.in_read_data = c_rdata; assign b0.in_read_data = c_rdata;
  assign b1.in_alu_result = c_alu; assign b0.in_alu_result = c_alu;
  assign b1.in_rd = c_rd;          assign b0.in_rd = c_rd;

  memwb_pipe #(.DATA_W(32), .RADDR_W(5), .SKID(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));
  memwb_pipe #(.DATA_W(32), .RADDR_W(5), .SKID(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));

  typedef struct {
    bit        rw;
    bit        m2r;
    bit [31:0] rdata;
    bit [31:0] alu;
    bit [4:0]  rd;
  } ent_t;

  ent_t q1[$];
  ent_t q0[$];
  int   cnt1 = 0, cnt0 = 0;
  int   n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t capture();
    ent_t e;
    e.rw    = c_rw && (c_rd != 5'd0);
    e.m2r   = c_m2r;
    e.rdata = c_rdata;
    e.alu   = c_alu;
    e.rd    = c_rd;
    return e;
  endfunction

  function automatic ent_t head1();
    ent_t e = '{default: 0};
    if (q1.size() > 0) e = q1[0];
    return e;
  endfunction

  function automatic ent_t head0();
    ent_t e = '{default: 0};
    if (q0.size() > 0) e = q0[0];
    return e;
  endfunction

  // Queue-level model: capacity 2 with ready = room at cycle start, or capacity 1 with pass-through ready.
  task automatic model_step();
    ent_t e = capture();
    bit   r1, r0, a1, a0, k1, k0;
    r1 = q1.size() < 2;
    r0 = (q0.size() == 0) || out_ready;
    a1 = in_valid && r1;
    a0 = in_valid && r0;
    k1 = (q1.size() > 0) && out_ready;
    k0 = (q0.size() > 0) && out_ready;
    if (q1.size() > 0 && !out_ready && cnt1 < 15)    cnt1++;
    if (q0.size() > 0 && !out_ready && cnt0 < 65535) cnt0++;
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (k1) void'(q1.pop_front());
      if (a1) q1.push_back(e);
      if (k0) void'(q0.pop_front());
      if (a0) q0.push_back(e);
    end
  endtask

  task automatic check_model(input string tag, input int sz, input ent_t h, input int cnt,
                             input bit rdy, input logic ov, input logic ir, input logic orw,
                             input logic om, input logic [31:0] ordata, input logic [31:0] oalu,
                             input logic [4:0] ord, input logic [31:0] wbd, input logic wbe,
                             input logic [31:0] sc);
    chk({tag, ".out_valid"}, 32'(ov), 32'(sz > 0));
    chk({tag, ".in_ready"}, 32'(ir), 32'(rdy));
    chk({tag, ".stall_cnt"}, sc, cnt);
    chk({tag, ".wb_en"}, 32'(wbe), 32'((sz > 0) && out_ready && h.rw));
    if (sz > 0) begin
      chk({tag, ".out_reg_write"}, 32'(orw), 32'(h.rw));
      chk({tag, ".out_mem_to_reg"}, 32'(om), 32'(h.m2r));
      chk({tag, ".out_read_data"}, ordata, h.rdata);
      chk({tag, ".out_alu_result"}, oalu, h.alu);
      chk({tag, ".out_rd"}, 32'(ord), 32'(h.rd));
      chk({tag, ".wb_data"}, wbd, h.m2r ? h.rdata : h.alu);
    end
  endtask

  always @(negedge clk) begin
    check_model("skid1", q1.size(), head1(), cnt1, q1.size() < 2,
                b1.out_valid, b1.in_ready, b1.out_reg_write, b1.out_mem_to_reg,
                b1.out_read_data, b1.out_alu_result, b1.out_rd, b1.wb_data, b1.wb_en,
                32'(b1.stall_cnt));
    check_model("skid0", q0.size(), head0(), cnt0, (q0.size() == 0) || out_ready,
                b0.out_valid, b0.in_ready, b0.out_reg_write, b0.out_mem_to_reg,
                b0.out_read_data, b0.out_alu_result, b0.out_rd, b0.wb_data, b0.wb_en,
                32'(b0.stall_cnt));
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic set_ent(input bit rw, input bit m2r, input logic [31:0] rdata,
                         input logic [31:0] alu, input logic [4:0] rd);
    c_rw = rw; c_m2r = m2r; c_rdata = rdata; c_alu = alu; c_rd = rd;
  endtask

  task automatic check_zero(input string tag, input logic ov, input logic ir, input logic orw,
                            input logic om, input logic [31:0] ordata, input logic [31:0] oalu,
                            input logic [4:0] ord, input logic [31:0] wbd, input logic wbe,
                            input logic [31:0] sc);
    chk({tag, ".rst.out_valid"}, 32'(ov), 32'd0);
    chk({tag, ".rst.in_ready"}, 32'(ir), 32'd1);
    chk({tag, ".rst.fields"}, {28'd0, orw, om, 2'b00}, 32'd0);
    chk({tag, ".rst.read_data"}, ordata, 32'd0);
    chk({tag, ".rst.alu_result"}, oalu, 32'd0);
    chk({tag, ".rst.rd"}, 32'(ord), 32'd0);
    chk({tag, ".rst.wb_data"}, wbd, 32'd0);
    chk({tag, ".rst.wb_en"}, 32'(wbe), 32'd0);
    chk({tag, ".rst.stall_cnt"}, sc, 32'd0);
  endtask

  task automatic check_reset_all();
    check_zero("skid1", b1.out_valid, b1.in_ready, b1.out_reg_write, b1.out_mem_to_reg,
               b1.out_read_data, b1.out_alu_result, b1.out_rd, b1.wb_data, b1.wb_en,
               32'(b1.stall_cnt));
    check_zero("skid0", b0.out_valid, b0.in_ready, b0.out_reg_write, b0.out_mem_to_reg,
               b0.out_read_data, b0.out_alu_result, b0.out_rd, b0.wb_data, b0.wb_en,
               32'(b0.stall_cnt));
  endtask

  // Asserts reset between clock edges and checks outputs before any edge arrives.
  task automatic async_reset();
    #1;
    rst_n = 1'b0;
    q1.delete();
    q0.delete();
    cnt1 = 0;
    cnt0 = 0;
    #1;
    check_reset_all();
  endtask

  task automatic do_reset();
    async_reset();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    flush = 0; in_valid = 0; out_ready = 0;
    set_ent(0, 0, 32'd0, 32'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_all();
    rst_n = 1'b1;

    // Single instruction through with downstream ready.
    out_ready = 1;
    set_ent(1, 0, 32'h5555_AAAA, 32'h0000_1234, 5'd5);
    in_valid = 1;
    tick();
    in_valid = 0;
    #1;
    chk("t1.out_valid", 32'(b1.out_valid), 32'd1);
    chk("t1.out_rd", 32'(b1.out_rd), 32'd5);
    chk("t1.wb_data", b1.wb_data, 32'h0000_1234);
    chk("t1.wb_en", 32'(b1.wb_en), 32'd1);
    tick();

    // Load data selected by mem_to_reg.
    set_ent(1, 1, 32'hDEAD_BEEF, 32'h0000_0001, 5'd7);
    in_valid = 1;
    tick();
    in_valid = 0;
    #1;
    chk("load.wb_data_s1", b1.wb_data, 32'hDEAD_BEEF);
    chk("load.wb_data_s0", b0.wb_data, 32'hDEAD_BEEF);
    tick();

    // Writes to x0 are suppressed.
    set_ent(1, 0, 32'd0, 32'h0000_0055, 5'd0);
    in_valid = 1;
    tick();
    in_valid = 0;
    #1;
    chk("x0.out_valid", 32'(b1.out_valid), 32'd1);
    chk("x0.out_reg_write", 32'(b1.out_reg_write), 32'd0);
    chk("x0.wb_en", 32'(b1.wb_en), 32'd0);
    tick();

    // Back-pressure: A, B fill the skid stage, C waits upstream.
    do_reset();
    out_ready = 0;
    set_ent(1, 0, 32'd0, 32'h0000_000A, 5'd1);
    in_valid = 1;
    tick();
    #1;
    chk("bp.ready_after_a", 32'(b1.in_ready), 32'd1);
    set_ent(1, 0, 32'd0, 32'h0000_000B, 5'd2);
    tick();
    #1;
    chk("bp.ready_after_b", 32'(b1.in_ready), 32'd0);
    chk("bp.head_a", b1.out_alu_result, 32'h0000_000A);
    set_ent(1, 0, 32'd0, 32'h0000_000C, 5'd3);
    tick();
    tick();
    #1;
    chk("bp.stall_cnt", 32'(b1.stall_cnt), 32'd3);
    chk("bp.head_still_a", b1.out_alu_result, 32'h0000_000A);
    out_ready = 1;
    tick();
    #1;
    chk("bp.head_b", b1.out_alu_result, 32'h0000_000B);
    chk("bp.ready_again", 32'(b1.in_ready), 32'd1);
    tick();
    in_valid = 0;
    #1;
    chk("bp.head_c", b1.out_alu_result, 32'h0000_000C);
    tick();
    #1;
    chk("bp.drained", 32'(b1.out_valid), 32'd0);
    chk("bp.stall_final", 32'(b1.stall_cnt), 32'd3);

    // Flush while full and with a new instruction offered.
    out_ready = 0;
    set_ent(1, 0, 32'd0, 32'h0000_0011, 5'd4);
    in_valid = 1;
    tick();
    set_ent(1, 0, 32'd0, 32'h0000_0022, 5'd4);
    tick();
    #1;
    chk("fl.full", 32'(b1.in_ready), 32'd0);
    flush = 1;
    set_ent(1, 0, 32'd0, 32'h0000_0033, 5'd4);
    tick();
    flush = 0;
    in_valid = 0;
    #1;
    chk("fl.out_valid", 32'(b1.out_valid), 32'd0);
    chk("fl.in_ready", 32'(b1.in_ready), 32'd1);
    out_ready = 1;
    repeat (3) tick();
    chk("fl.stays_empty", 32'(b1.out_valid), 32'd0);

    // Counter saturation then reset with no clock edge.
    do_reset();
    out_ready = 0;
    set_ent(1, 0, 32'd0, 32'h0000_0077, 5'd9);
    in_valid = 1;
    tick();
    in_valid = 0;
    repeat (20) tick();
    #1;
    chk("sat.stall_cnt_s1", 32'(b1.stall_cnt), 32'd15);
    chk("sat.stall_cnt_s0", 32'(b0.stall_cnt), 32'd20);
    async_reset();
    tick();
    rst_n = 1'b1;

    // Randomized traffic with occasional flush and mid-stream reset.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      set_ent(1'($urandom), 1'($urandom), $urandom, $urandom,
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
        tick();
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
